// File: rtl/cgra_data_mem_if.sv
// Tile-side request/response bundle for the shared CGRA data memory.
// Each per-port field is packed port-major: port i occupies slice [i*W +: W].
interface cgra_data_mem_if #(
   parameter int N_PORTS = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int REG_W   = 3
);
   logic [N_PORTS-1:0]        req_valid;
   logic [N_PORTS-1:0]        req_ready;
   logic [N_PORTS-1:0]        req_we;
   logic [N_PORTS*ADDR_W-1:0] req_addr;
   logic [N_PORTS*DATA_W-1:0] req_wdata;
   logic [N_PORTS*REG_W-1:0]  req_reg;
   logic [N_PORTS-1:0]        rsp_valid;
   logic [N_PORTS*DATA_W-1:0] rsp_data;
   logic [N_PORTS*REG_W-1:0]  rsp_reg;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_reg,
      input  req_ready, rsp_valid, rsp_data, rsp_reg
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_reg,
      output req_ready, rsp_valid, rsp_data, rsp_reg
   );
endinterface

// File: rtl/cgra_data_mem.sv
// Shared CGRA data memory: round-robin arbitration of tile load/store requests onto one RAM port.
// Optional feature macro CGRA_DMEM_WACK_EN: accepted stores also return a one-cycle acknowledge.
module cgra_data_mem #(
   parameter int N_PORTS = 4,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int REG_W   = 3
) (
   input  logic           clk,
   input  logic           rst,
   cgra_data_mem_if.slave bus,
   output logic           init_done
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   init_cnt;
   logic [ADDR_W-1:0]   init_cnt_nxt;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_ptr_nxt;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                gnt_any_p0;
   logic [PTR_W-1:0]    gnt_idx_p0;
   logic                accept_p0;
   logic [N_PORTS-1:0]  ready_p0;
   logic                sel_we_p0;
   logic [ADDR_W-1:0]   sel_addr_p0;
   logic [DATA_W-1:0]   sel_wdata_p0;
   logic [REG_W-1:0]    sel_reg_p0;
   logic                sel_in_range_p0;
   logic [DATA_W-1:0]   rd_data_p0;
   logic                rsp_fire_p0;
   logic [DATA_W-1:0]   rsp_word_p0;

   logic [N_PORTS-1:0]        rsp_vld_p1;
   logic [N_PORTS*DATA_W-1:0] rsp_data_p1;
   logic [N_PORTS*REG_W-1:0]  rsp_reg_p1;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---- p0: round-robin search starting at rr_ptr, wrapping modulo N_PORTS
   always_comb begin
      int idx;
      idx        = 0;
      gnt_any_p0 = 1'b0;
      gnt_idx_p0 = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         idx = (int'(rr_ptr) + i) % N_PORTS;
         if (!gnt_any_p0 && bus.req_valid[idx]) begin
            gnt_any_p0 = 1'b1;
            gnt_idx_p0 = PTR_W'(idx);
         end
      end
   end

   // ---- p0: granted request field mux and combinational RAM read
   always_comb begin
      int g;
      g               = int'(gnt_idx_p0);
      accept_p0       = (state == RUN) && gnt_any_p0;
      ready_p0        = '0;
      if (accept_p0) ready_p0[g] = 1'b1;
      sel_we_p0       = bus.req_we[g];
      sel_addr_p0     = bus.req_addr[g*ADDR_W +: ADDR_W];
      sel_wdata_p0    = bus.req_wdata[g*DATA_W +: DATA_W];
      sel_reg_p0      = bus.req_reg[g*REG_W +: REG_W];
      sel_in_range_p0 = addr_ok(sel_addr_p0);
      rd_data_p0      = sel_in_range_p0 ? mem[sel_addr_p0] : '0;
`ifdef CGRA_DMEM_WACK_EN
      rsp_fire_p0     = accept_p0;
      rsp_word_p0     = sel_we_p0 ? (sel_in_range_p0 ? sel_wdata_p0 : '0) : rd_data_p0;
`else
      rsp_fire_p0     = accept_p0 && !sel_we_p0;
      rsp_word_p0     = rd_data_p0;
`endif
   end

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      rr_ptr_nxt   = rr_ptr;
      unique case (state)
         INIT: begin
            init_cnt_nxt = init_cnt + 1'b1;
            if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
         end
         RUN: begin
            if (accept_p0) rr_ptr_nxt = next_ptr(gnt_idx_p0);
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= INIT;
         init_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
         rr_ptr   <= rr_ptr_nxt;
      end
   end

   // The init sweep owns the single write port until it finishes; requests are never granted meanwhile.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[init_cnt] <= '0;
      end else if (accept_p0 && sel_we_p0 && sel_in_range_p0) begin
         mem[sel_addr_p0] <= sel_wdata_p0;
      end
   end

   // ---- p1: registered response, one-cycle pulse; idle ports keep their last data/reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_vld_p1  <= '0;
         rsp_data_p1 <= '0;
         rsp_reg_p1  <= '0;
      end else begin
         rsp_vld_p1 <= '0;
         if (rsp_fire_p0) begin
            rsp_vld_p1[gnt_idx_p0]                         <= 1'b1;
            rsp_data_p1[int'(gnt_idx_p0)*DATA_W +: DATA_W] <= rsp_word_p0;
            rsp_reg_p1[int'(gnt_idx_p0)*REG_W +: REG_W]    <= sel_reg_p0;
         end
      end
   end

   assign bus.req_ready = ready_p0;
   assign bus.rsp_valid = rsp_vld_p1;
   assign bus.rsp_data  = rsp_data_p1;
   assign bus.rsp_reg   = rsp_reg_p1;
   assign init_done     = (state == RUN);

endmodule
